// File: rtl/binary_to_gray_stream_if.sv
// rtl/binary_to_gray_stream_if.sv - valid/ready bus between a binary source and a Gray sink
//
// in_valid/in_ready/in_bin : binary words toward the encoder
// out_valid/out_ready/out_gray/out_first/out_step : encoded words from the encoder
// master : the side that supplies binary words and consumes Gray words
// slave  : the encoder

interface binary_to_gray_stream_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gray;
    logic             out_first;
    logic             out_step;

    modport master (
        output in_valid,
        output in_bin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_gray,
        input  out_first,
        input  out_step
    );

    modport slave (
        input  in_valid,
        input  in_bin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_gray,
        output out_first,
        output out_step
    );
endinterface

// File: rtl/binary_to_gray_stream.sv
// rtl/binary_to_gray_stream.sv - streaming binary-to-Gray encoder with skid buffer and adjacency flag
//
// clk   : single clock, rising edge
// rst_n : synchronous active-low reset
// bus   : slave side of binary_to_gray_stream_if; WIDTH must match the interface
//         in_*  : binary word handshake (in_ready depends only on registers and rst_n)
//         out_* : registered Gray word, first-since-reset flag, single-bit-step flag

module binary_to_gray_stream #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    binary_to_gray_stream_if.slave   bus
);

    // Output register (OR) and skid register (SK) hold already-encoded words.
    logic [WIDTH-1:0] or_data_q,   or_data_d;
    logic             or_valid_q,  or_valid_d;
    logic [WIDTH-1:0] sk_data_q,   sk_data_d;
    logic             sk_valid_q,  sk_valid_d;
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic             seen_any_q,  seen_any_d;

    logic             in_fire;
    logic             out_fire;
    logic             or_load;
    logic [WIDTH-1:0] gray_in;
    logic [WIDTH-1:0] diff;

    assign gray_in  = bus.in_bin ^ (bus.in_bin >> 1);

    assign bus.in_ready  = rst_n && !sk_valid_q;
    assign bus.out_valid = or_valid_q;
    assign bus.out_gray  = or_data_q;
    assign bus.out_first = !seen_any_q;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign diff         = or_data_q ^ prev_gray_q;
    assign bus.out_step = seen_any_q && (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = or_valid_q && bus.out_ready;
    assign or_load  = !or_valid_q || out_fire;

    always_comb begin
        or_data_d   = or_data_q;
        or_valid_d  = or_valid_q;
        sk_data_d   = sk_data_q;
        sk_valid_d  = sk_valid_q;
        prev_gray_d = prev_gray_q;
        seen_any_d  = seen_any_q;

        if (or_load) begin
            if (sk_valid_q) begin
                // Older skid word moves forward first; a new word waits behind it.
                or_data_d  = sk_data_q;
                or_valid_d = 1'b1;
                sk_valid_d = in_fire;
                if (in_fire) begin
                    sk_data_d = gray_in;
                end
            end else begin
                or_valid_d = in_fire;
                if (in_fire) begin
                    or_data_d = gray_in;
                end
            end
        end else if (in_fire) begin
            sk_data_d  = gray_in;
            sk_valid_d = 1'b1;
        end

        if (out_fire) begin
            prev_gray_d = or_data_q;
            seen_any_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_data_q   <= '0;
            or_valid_q  <= 1'b0;
            sk_data_q   <= '0;
            sk_valid_q  <= 1'b0;
            prev_gray_q <= '0;
            seen_any_q  <= 1'b0;
        end else begin
            or_data_q   <= or_data_d;
            or_valid_q  <= or_valid_d;
            sk_data_q   <= sk_data_d;
            sk_valid_q  <= sk_valid_d;
            prev_gray_q <= prev_gray_d;
            seen_any_q  <= seen_any_d;
        end
    end

endmodule

// File: tb/tb_binary_to_gray_stream.sv
// tb/tb_binary_to_gray_stream.sv - directed and randomized checks for binary_to_gray_stream

module tb_binary_to_gray_stream;

    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    binary_to_gray_stream_if #(.WIDTH(W)) bus ();

    binary_to_gray_stream #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ref_gray(input logic [W-1:0] b);
        logic [W-1:0] g;
        g[W-1] = b[W-1];
        for (int i = 0; i < W - 1; i++) g[i] = b[i+1] ^ b[i];
        return g;
    endfunction

    function automatic int ref_popcount(input logic [W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) n += int'(v[i]);
        return n;
    endfunction

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_prev;
    logic         m_seen;
    logic         hold_pending;
    logic [W-1:0] hold_gray;
    logic         hold_first;
    logic         hold_step;
    logic [W-1:0] e;
    int           bound;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bin = '0;
        bus.out_ready = 1'b1;
        step();
        step();

        // reset state
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_first", 32'(bus.out_first), 32'd1);
        chk("rst_out_step",  32'(bus.out_step),  32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);

        // single word 5 -> 0111
        bus.in_valid = 1'b1; bus.in_bin = 4'd5;
        step();
        bus.in_valid = 1'b0;
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_gray",  32'(bus.out_gray),  32'b0111);
        chk("t1_first", 32'(bus.out_first), 32'd1);
        chk("t1_step",  32'(bus.out_step),  32'd0);
        step();
        chk("t1_drained", 32'(bus.out_valid), 32'd0);
        chk("t1_first_after", 32'(bus.out_first), 32'd0);

        // back-to-back 7, 8 after a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.in_valid = 1'b1; bus.in_bin = 4'd7;
        step();
        chk("t2_gray7",  32'(bus.out_gray),  32'b0100);
        chk("t2_first7", 32'(bus.out_first), 32'd1);
        bus.in_bin = 4'd8;
        step();
        bus.in_valid = 1'b0;
        chk("t2_valid8", 32'(bus.out_valid), 32'd1);
        chk("t2_gray8",  32'(bus.out_gray),  32'b1100);
        chk("t2_step8",  32'(bus.out_step),  32'd1);
        chk("t2_first8", 32'(bus.out_first), 32'd0);
        step();
        chk("t2_drained", 32'(bus.out_valid), 32'd0);

        // backpressure: 1, 2, 3 with out_ready low
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_bin = 4'd1;
        step();
        chk("t3_ready_after1", 32'(bus.in_ready), 32'd1);
        bus.in_bin = 4'd2;
        step();
        chk("t3_ready_after2", 32'(bus.in_ready), 32'd0);
        chk("t3_gray_hold1",   32'(bus.out_gray), 32'b0001);
        chk("t3_sk_data",      32'(dut.sk_data_q), 32'b0011);
        bus.in_bin = 4'd3;
        step();
        chk("t3_gray_hold2",   32'(bus.out_gray), 32'b0001);
        chk("t3_ready_stall",  32'(bus.in_ready), 32'd0);
        chk("t3_valid_hold",   32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step();
        chk("t3_gray2",  32'(bus.out_gray), 32'b0011);
        chk("t3_step2",  32'(bus.out_step), 32'd1);
        chk("t3_ready_back", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("t3_gray3",  32'(bus.out_gray), 32'b0010);
        chk("t3_step3",  32'(bus.out_step), 32'd1);
        step();
        chk("t3_drained", 32'(bus.out_valid), 32'd0);

        // wrap-around 15 -> 0, then non-adjacent and identical words
        bus.in_valid = 1'b1; bus.in_bin = 4'd15;
        step();
        chk("t4_gray15", 32'(bus.out_gray), 32'b1000);
        bus.in_bin = 4'd0;
        step();
        chk("t4_gray0",  32'(bus.out_gray), 32'b0000);
        chk("t4_step0",  32'(bus.out_step), 32'd1);
        bus.in_bin = 4'd5;
        step();
        chk("t4_gray5",  32'(bus.out_gray), 32'b0111);
        chk("t4_step5",  32'(bus.out_step), 32'd0);
        step();
        bus.in_valid = 1'b0;
        chk("t4_same_gray", 32'(bus.out_gray), 32'b0111);
        chk("t4_same_step", 32'(bus.out_step), 32'd0);
        step();

        // reset with OR and SK both full
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_bin = 4'd9;
        step();
        bus.in_bin = 4'd10;
        step();
        chk("t5_full_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_rst_first", 32'(bus.out_first), 32'd1);
        chk("t5_rst_ready", 32'(bus.in_ready),  32'd0);
        chk("t5_rst_step",  32'(bus.out_step),  32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_bin = 4'd2;
        step();
        bus.in_valid = 1'b0;
        chk("t5_post_valid", 32'(bus.out_valid), 32'd1);
        chk("t5_post_gray",  32'(bus.out_gray),  32'b0011);
        chk("t5_post_first", 32'(bus.out_first), 32'd1);
        step();
        chk("t5_no_stale", 32'(bus.out_valid), 32'd0);

        // random traffic against a queue and popcount model; fresh reset so the model starts clean
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_seen = 1'b0;
        m_prev = '0;
        hold_pending = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_bin    = W'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (hold_pending) begin
                chk("rnd_hold_gray",  32'(bus.out_gray),  32'(hold_gray));
                chk("rnd_hold_first", 32'(bus.out_first), 32'(hold_first));
                chk("rnd_hold_step",  32'(bus.out_step),  32'(hold_step));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_gray",  32'(bus.out_gray),  32'(e));
                    chk("rnd_first", 32'(bus.out_first), 32'(!m_seen));
                    chk("rnd_step",  32'(bus.out_step),
                        32'(m_seen && (ref_popcount(e ^ m_prev) == 1)));
                    m_prev = e;
                    m_seen = 1'b1;
                end
            end
            hold_pending = bus.out_valid && !bus.out_ready;
            hold_gray    = bus.out_gray;
            hold_first   = bus.out_first;
            hold_step    = bus.out_step;
            if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_gray(bus.in_bin));
            step();
        end

        // drain with a cycle bound
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bound = 0;
        while (exp_q.size() != 0 && bound < 20) begin
            @(negedge clk);
            if (bus.out_valid) begin
                e = exp_q.pop_front();
                chk("drain_gray", 32'(bus.out_gray), 32'(e));
            end
            step();
            bound++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        #1;
        chk("drain_idle", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
